// File: rtl/mux_scan_ctrl.sv
// Scan controller for mux8to1: latches a word, walks the select 0..7, samples y into captured.
// Define MUX_SCAN_CHECK_EN to build the per-bit comparison (err_mask/err); otherwise they read 0.
module mux_scan_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data_in,
    output logic [7:0] d,
    output logic [2:0] s,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic [7:0] captured,
    output logic [7:0] err_mask,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, FINISH} state_t;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [7:0] dat_q, dat_d;
    logic [2:0] sel_q, sel_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] cap_q, cap_d;
`ifdef MUX_SCAN_CHECK_EN
    logic [7:0] mask_q, mask_d;
    logic       err_q, err_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dat_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            cap_q   <= '0;
`ifdef MUX_SCAN_CHECK_EN
            mask_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
`ifdef MUX_SCAN_CHECK_EN
            mask_q  <= mask_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
`ifdef MUX_SCAN_CHECK_EN
        mask_d  = mask_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT;
                    dat_d   = data_in;
                    sel_d   = '0;
                    cnt_d   = CNT_INIT;
                    cap_d   = '0;
`ifdef MUX_SCAN_CHECK_EN
                    mask_d  = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = CAPTURE;
                else             cnt_d   = cnt_q - 4'd1;
            end
            CAPTURE: begin
                // y has had SETTLE full cycles on this select value
                cap_d[sel_q] = y;
`ifdef MUX_SCAN_CHECK_EN
                mask_d[sel_q] = y ^ dat_q[sel_q];
`endif
                if (sel_q == 3'd7) begin
                    state_d = FINISH;
                end else begin
                    sel_d   = sel_q + 3'd1;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            FINISH: begin
`ifdef MUX_SCAN_CHECK_EN
                err_d = |mask_q;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign d        = dat_q;
    assign s        = sel_q;
    assign busy     = (state_q == WAIT) || (state_q == CAPTURE);
    assign done     = (state_q == FINISH);
    assign captured = cap_q;
`ifdef MUX_SCAN_CHECK_EN
    assign err_mask = mask_q;
    assign err      = err_q;
`else
    assign err_mask = '0;
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: two instances (SETTLE=1 and SETTLE=3) driven by a behavioural mux,
// checked every cycle against a timeline model counted from the accepted start edge.
module tb_mux_scan_ctrl;

`ifdef MUX_SCAN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_w  [2];
    logic [7:0] din_w    [2];
    logic [7:0] d_w      [2];
    logic [2:0] s_w      [2];
    logic       y_w      [2];
    logic       busy_w   [2];
    logic       done_w   [2];
    logic [7:0] cap_w    [2];
    logic [7:0] mask_w   [2];
    logic       err_w    [2];
    logic       fault    [2];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    // behavioural mux, optionally corrupting the s=3 path
    assign y_w[0] = d_w[0][s_w[0]] ^ (fault[0] && s_w[0] == 3'd3);
    assign y_w[1] = d_w[1][s_w[1]] ^ (fault[1] && s_w[1] == 3'd3);

    mux_scan_ctrl #(.SETTLE(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_w[0]), .data_in(din_w[0]),
        .d(d_w[0]), .s(s_w[0]), .y(y_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .captured(cap_w[0]), .err_mask(mask_w[0]), .err(err_w[0])
    );

    mux_scan_ctrl #(.SETTLE(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_w[1]), .data_in(din_w[1]),
        .d(d_w[1]), .s(s_w[1]), .y(y_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .captured(cap_w[1]), .err_mask(mask_w[1]), .err(err_w[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- model: cycles elapsed since the accepted start edge ----------------
    int         m_n    [2] = '{-1, -1};
    logic [7:0] m_data [2] = '{8'h00, 8'h00};
    logic       m_flt  [2] = '{1'b0, 1'b0};
    int         m_e0   [2] = '{0, 0};

    function automatic int settle_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int len_of(input int k);
        return 8 * (settle_of(k) + 1);
    endfunction

    function automatic bit m_idle(input int k);
        return (m_n[k] < 0) || (m_n[k] >= len_of(k) + 1);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_n[k]    <= -1;
                m_data[k] <= 8'h00;
                m_flt[k]  <= 1'b0;
            end else if (start_w[k] && m_idle(k)) begin
                m_n[k]    <= 0;
                m_data[k] <= din_w[k];
                m_flt[k]  <= fault[k];
                m_e0[k]   <= cyc + 1;
            end else if (m_n[k] >= 0 && m_n[k] < 1000) begin
                m_n[k]    <= m_n[k] + 1;
            end
        end
    end

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] s;
        logic       busy;
        logic       done;
        logic [7:0] cap;
        logic [7:0] mask;
        logic       err;
    } exp_t;

    function automatic exp_t model_out(input int k);
        exp_t e;
        int   per, n;
        e   = '0;
        per = settle_of(k) + 1;
        n   = m_n[k];
        if (n >= 0) begin
            e.d    = m_data[k];
            e.s    = 3'((n / per > 7) ? 7 : n / per);
            e.busy = n < 8 * per;
            e.done = n == 8 * per;
            for (int i = 0; i < 8; i++) begin
                if ((i + 1) * per <= n) begin
                    e.cap[i]  = m_data[k][i] ^ (m_flt[k] && i == 3);
                    e.mask[i] = CHK && m_flt[k] && i == 3;
                end
            end
            e.err = (n >= 8 * per + 1) && (|e.mask);
        end
        return e;
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            e = model_out(k);
            chk($sformatf("ch%0d d", k),        d_w[k],    e.d);
            chk($sformatf("ch%0d s", k),        s_w[k],    e.s);
            chk($sformatf("ch%0d busy", k),     busy_w[k], e.busy);
            chk($sformatf("ch%0d done", k),     done_w[k], e.done);
            chk($sformatf("ch%0d captured", k), cap_w[k],  e.cap);
            chk($sformatf("ch%0d err_mask", k), mask_w[k], e.mask);
            chk($sformatf("ch%0d err", k),      err_w[k],  e.err);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int k, input logic [7:0] v);
        start_w[k] = 1'b1;
        din_w[k]   = v;
        tick();
        start_w[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_w[k]) break;
        end
        if (i == budget) chk($sformatf("ch%0d done timeout", k), 0, 1);
    endtask

    int ndone;

    initial begin
        rst_n   = 1'b1;
        start_w = '{1'b0, 1'b0};
        din_w   = '{8'h00, 8'h00};
        fault   = '{1'b0, 1'b0};
        #1 rst_n = 1'b0;
        repeat (3) tick();
        chk("reset d", d_w[0], 8'h00);
        chk("reset busy", busy_w[0], 1'b0);
        chk("reset captured", cap_w[1], 8'h00);
        rst_n = 1'b1;
        tick();

        // clean scan of AA; a second start while busy must be ignored
        pulse_start(0, 8'hAA);
        repeat (3) tick();
        pulse_start(0, 8'h55);
        wait_done(0, 100);
        chk("AA latency", cyc - m_e0[0], 16);
        chk("AA captured", cap_w[0], 8'hAA);
        chk("AA err_mask", mask_w[0], 8'h00);
        tick();
        chk("AA err", err_w[0], 1'b0);

        // corrupted bit 3
        fault[0] = 1'b1;
        pulse_start(0, 8'hAA);
        wait_done(0, 100);
        chk("f3 captured", cap_w[0], 8'hA2);
        chk("f3 err_mask", mask_w[0], CHK ? 8'h08 : 8'h00);
        tick();
        chk("f3 err", err_w[0], CHK);
        fault[0] = 1'b0;

        pulse_start(0, 8'h55);
        wait_done(0, 100);
        chk("55 captured", cap_w[0], 8'h55);
        tick();

        // reset in the middle of a scan at s=4
        pulse_start(0, 8'hC3);
        for (int i = 0; i < 40 && s_w[0] != 3'd4; i++) @(negedge clk);
        chk("reached s4", s_w[0], 3'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("abort d", d_w[0], 8'h00);
        chk("abort s", s_w[0], 3'd0);
        chk("abort busy", busy_w[0], 1'b0);
        chk("abort captured", cap_w[0], 8'h00);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        pulse_start(0, 8'hF0);
        wait_done(0, 100);
        chk("F0 captured", cap_w[0], 8'hF0);

        // SETTLE=3 instance
        pulse_start(1, 8'h3C);
        wait_done(1, 200);
        chk("S3 latency", cyc - m_e0[1], 32);
        chk("S3 captured", cap_w[1], 8'h3C);
        repeat (2) tick();

        // start held high: back-to-back scans every 18 cycles
        ndone = 0;
        start_w[0] = 1'b1;
        for (int j = 0; j < 54; j++) begin
            din_w[0] = 8'($urandom);
            tick();
            if (done_w[0]) ndone++;
        end
        start_w[0] = 1'b0;
        chk("b2b done count", ndone, 3);
        repeat (20) tick();

        // random start/data/fault on both instances
        for (int j = 0; j < 600; j++) begin
            for (int k = 0; k < 2; k++) begin
                start_w[k] = ($urandom_range(0, 5) == 0);
                din_w[k]   = 8'($urandom);
                if (m_idle(k)) fault[k] = ($urandom_range(0, 2) == 0);
            end
            tick();
        end
        start_w = '{1'b0, 1'b0};
        repeat (40) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
